// File: rtl/common.sv
// Common scalar types shared across the core.
package common;

  typedef logic [31:0] u32;
  typedef u32 word_t;

endpackage

// File: rtl/pipes.sv
// Pipeline-level types: arbiter FSM states and memory port owners.
package pipes;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } arb_owner_t;

endpackage

// File: rtl/arb_select.sv
// Combinational grant pick between the fetch and data requesters.
// Data wins collisions unless MEM_ARBITER_RR_EN rotates on the last owner.
module arb_select
  import pipes::*;
(
  input  logic       i_req,
  input  logic       d_req,
`ifdef MEM_ARBITER_RR_EN
  input  arb_owner_t last,
`endif
  output logic       gnt_i,
  output logic       gnt_d
);

  logic pick_i;

`ifdef MEM_ARBITER_RR_EN
  assign pick_i = (last == OWN_D);
`else
  assign pick_i = 1'b0;
`endif

  always_comb begin
    gnt_i = 1'b0;
    gnt_d = 1'b0;
    if (i_req && d_req) begin
      gnt_i = pick_i;
      gnt_d = ~pick_i;
    end else begin
      gnt_i = i_req;
      gnt_d = d_req;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between instruction fetch and data access.
// MEM_ARBITER_RR_EN: round-robin on collisions instead of data priority.
module mem_arbiter
  import common::*;
  import pipes::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  i_req,
  input  word_t i_addr,
  output word_t i_rdata,
  output logic  i_ready,
  input  logic  d_req,
  input  logic  d_we,
  input  word_t d_addr,
  input  word_t d_wdata,
  output word_t d_rdata,
  output logic  d_ready,
  output logic  m_req,
  output logic  m_we,
  output word_t m_addr,
  output word_t m_wdata,
  input  word_t m_rdata,
  input  logic  m_ack,
  output logic  stall,
  output logic  err
);

  localparam logic [7:0] TimeoutLim = 8'(TIMEOUT_CYCLES);

  arb_state_t state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       m_req_q, m_req_d;
  logic       m_we_q, m_we_d;
  word_t      m_addr_q, m_addr_d;
  word_t      m_wdata_q, m_wdata_d;
  word_t      i_rdata_q, i_rdata_d;
  word_t      d_rdata_q, d_rdata_d;
  logic       i_ready_q, i_ready_d;
  logic       d_ready_q, d_ready_d;
  logic       err_q, err_d;
  logic       can_grant, gnt_i, gnt_d, expire;
`ifdef MEM_ARBITER_RR_EN
  arb_owner_t last_q, last_d;
`endif

  // No grant during the ready pulse: the requester still holds req then.
  assign can_grant = (state_q == IDLE) & ~i_ready_q & ~d_ready_q;
  assign expire    = (cnt_q + 8'd1) == TimeoutLim;

  arb_select u_sel (
    .i_req (i_req & can_grant),
    .d_req (d_req & can_grant),
`ifdef MEM_ARBITER_RR_EN
    .last  (last_q),
`endif
    .gnt_i (gnt_i),
    .gnt_d (gnt_d)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    m_req_d   = m_req_q;
    m_we_d    = m_we_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    i_ready_d = 1'b0;
    d_ready_d = 1'b0;
    err_d     = 1'b0;
`ifdef MEM_ARBITER_RR_EN
    last_d    = last_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (gnt_d) begin
          state_d   = BUSY_D;
          m_req_d   = 1'b1;
          m_we_d    = d_we;
          m_addr_d  = d_addr;
          m_wdata_d = d_wdata;
          cnt_d     = 8'd0;
        end else if (gnt_i) begin
          state_d   = BUSY_I;
          m_req_d   = 1'b1;
          m_we_d    = 1'b0;
          m_addr_d  = i_addr;
          m_wdata_d = '0;
          cnt_d     = 8'd0;
        end
      end
      BUSY_I: begin
        if (m_ack || expire) begin
          state_d   = IDLE;
          m_req_d   = 1'b0;
          i_ready_d = 1'b1;
          err_d     = ~m_ack;
          i_rdata_d = m_ack ? m_rdata : '0;
`ifdef MEM_ARBITER_RR_EN
          last_d    = OWN_I;
`endif
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      BUSY_D: begin
        if (m_ack || expire) begin
          state_d   = IDLE;
          m_req_d   = 1'b0;
          d_ready_d = 1'b1;
          err_d     = ~m_ack;
          if (!m_ack)
            d_rdata_d = '0;
          else if (!m_we_q)
            d_rdata_d = m_rdata;
`ifdef MEM_ARBITER_RR_EN
          last_d    = OWN_D;
`endif
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= 8'd0;
      m_req_q   <= 1'b0;
      m_we_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      i_ready_q <= 1'b0;
      d_ready_q <= 1'b0;
      err_q     <= 1'b0;
`ifdef MEM_ARBITER_RR_EN
      last_q    <= OWN_D;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      m_req_q   <= m_req_d;
      m_we_q    <= m_we_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      i_ready_q <= i_ready_d;
      d_ready_q <= d_ready_d;
      err_q     <= err_d;
`ifdef MEM_ARBITER_RR_EN
      last_q    <= last_d;
`endif
    end
  end

  assign i_rdata = i_rdata_q;
  assign i_ready = i_ready_q;
  assign d_rdata = d_rdata_q;
  assign d_ready = d_ready_q;
  assign m_req   = m_req_q;
  assign m_we    = m_we_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign err     = err_q;
  assign stall   = (i_req & ~i_ready_q) | (d_req & ~d_ready_q);

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized scoreboard bench for mem_arbiter with a behavioural memory.
// The bench acts as both requesters and as the memory behind the port.
module tb_mem_arbiter;
  import common::*;

  localparam int TO = 16;

  logic  clk = 1'b0;
  logic  reset = 1'b1;
  logic  i_req = 1'b0;
  word_t i_addr = '0;
  word_t i_rdata;
  logic  i_ready;
  logic  d_req = 1'b0;
  logic  d_we = 1'b0;
  word_t d_addr = '0;
  word_t d_wdata = '0;
  word_t d_rdata;
  logic  d_ready;
  logic  m_req;
  logic  m_we;
  word_t m_addr;
  word_t m_wdata;
  word_t m_rdata = '0;
  logic  m_ack = 1'b0;
  logic  stall;
  logic  err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    bit    side;
    word_t rdata;
    bit    err;
    int    cyc;
  } exp_t;

  exp_t exp_q[$];
  word_t mem [word_t];

  bit f_pend = 0, d_pend = 0;
  int f_wait = 1, d_wait = 2;
  bit snap_i = 0, snap_d = 0, snap_we = 0;
  word_t snap_ia = '0, snap_da = '0, snap_dw = '0;
  bit rr_last_d = 1;
  word_t exp_i = '0, exp_d = '0;
  bit busy = 0, b_bad = 0, b_side = 0, b_we = 0;
  word_t b_addr = '0, b_wdata = '0;
  int rise_cyc = 0, delay = 0;
  bit prev_req = 0, prev_rdy = 0;
  bit run_rand = 0, hold_ack = 0, d_shot = 0, force_ack = 0;

  mem_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk     (clk),
    .reset   (reset),
    .i_req   (i_req),
    .i_addr  (i_addr),
    .i_rdata (i_rdata),
    .i_ready (i_ready),
    .d_req   (d_req),
    .d_we    (d_we),
    .d_addr  (d_addr),
    .d_wdata (d_wdata),
    .d_rdata (d_rdata),
    .d_ready (d_ready),
    .m_req   (m_req),
    .m_we    (m_we),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .m_rdata (m_rdata),
    .m_ack   (m_ack),
    .stall   (stall),
    .err     (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic word_t rd(word_t a);
    return mem.exists(a) ? mem[a] : (a * 32'h9E3779B1) ^ 32'h2402000A;
  endfunction

  // Requesters and memory, all driven at the falling edge.
  always @(negedge clk) begin : stim
    bit side, to;
    int lim;
    if (reset) begin
      i_req = 0; d_req = 0; m_ack = 0;
      f_pend = 0; d_pend = 0; busy = 0;
      rr_last_d = 1; prev_req = 0; prev_rdy = 0;
      snap_i = 0; snap_d = 0;
      exp_i = '0; exp_d = '0;
    end else begin
      chk("stall", stall, (i_req & ~i_ready) | (d_req & ~d_ready));
      if (m_req && !prev_req) begin
        chk("no_grant_in_ready", prev_rdy, 0);
        chk("grant_has_req", snap_i | snap_d, 1);
        if (snap_i && snap_d) begin
`ifdef MEM_ARBITER_RR_EN
          side = !rr_last_d;
`else
          side = 1;
`endif
        end else begin
          side = snap_d;
        end
        rr_last_d = side;
        delay = ($urandom_range(0, 5) == 0) ?
                $urandom_range(TO - 2, TO + 2) : $urandom_range(0, 3);
        to = delay >= TO;
        lim = to ? TO - 1 : delay;
        if (side) begin
          chk("m_addr_d", m_addr, snap_da);
          chk("m_we_d", m_we, snap_we);
          if (snap_we) chk("m_wdata", m_wdata, snap_dw);
          if (to) exp_d = '0;
          else if (snap_we) mem[snap_da] = snap_dw;
          else exp_d = rd(snap_da);
          exp_q.push_back('{1'b1, exp_d, to, cyc + lim + 1});
        end else begin
          chk("m_addr_i", m_addr, snap_ia);
          chk("m_we_i", m_we, 0);
          exp_i = to ? '0 : rd(snap_ia);
          exp_q.push_back('{1'b0, exp_i, to, cyc + lim + 1});
        end
        busy = 1; b_bad = 0; b_side = side; rise_cyc = cyc;
        b_addr = m_addr; b_we = m_we; b_wdata = m_wdata;
      end
      if (busy && m_req &&
          (m_addr !== b_addr || m_we !== b_we || m_wdata !== b_wdata))
        b_bad = 1;
      if (busy && !m_req) begin
        busy = 0;
        chk("m_stable", b_bad, 0);
      end
      m_ack = 0;
      m_rdata = $urandom;
      if (busy && m_req) begin
        if (!hold_ack && delay < TO && cyc - rise_cyc == delay) begin
          m_ack = 1;
          if (!(b_side && b_we)) m_rdata = rd(b_addr);
        end
      end else if (force_ack || $urandom_range(0, 7) == 0) begin
        m_ack = 1;
      end
      if (f_pend && i_ready) begin
        f_pend = 0; i_req = 0; f_wait = $urandom_range(1, 4);
      end else if (!f_pend) begin
        if (f_wait > 0) f_wait--;
        else if (run_rand) begin
          f_pend = 1; i_req = 1;
          i_addr = 32'h1000 + 32'($urandom_range(0, 15)) * 4;
        end
      end
      if (d_pend && d_ready) begin
        d_pend = 0; d_req = 0; d_wait = $urandom_range(1, 4);
      end else if (!d_pend) begin
        if (d_wait > 0) d_wait--;
        else if (d_shot) begin
          d_shot = 0; d_pend = 1; d_req = 1; d_we = 0; d_addr = 32'h40;
        end else if (run_rand) begin
          d_pend = 1; d_req = 1;
          d_we = ($urandom_range(0, 2) == 0);
          d_addr = 32'($urandom_range(0, 15)) * 4;
          d_wdata = $urandom;
        end
      end
      snap_i = i_req; snap_d = d_req; snap_we = d_we;
      snap_ia = i_addr; snap_da = d_addr; snap_dw = d_wdata;
      prev_req = m_req;
      prev_rdy = i_ready | d_ready;
    end
  end

  // Scoreboard monitor: pops one expectation per ready pulse.
  always @(negedge clk) begin : mon
    exp_t e;
    if (!reset) begin
      if (i_ready || d_ready) begin
        chk("one_ready", i_ready & d_ready, 0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ready: got i=%0b d=%0b expected none",
                   i_ready, d_ready);
        end else begin
          e = exp_q.pop_front();
          chk("owner", d_ready, e.side);
          chk("rdata", d_ready ? d_rdata : i_rdata, e.rdata);
          chk("err", err, e.err);
          chk("latency", cyc, e.cyc);
        end
      end else begin
        chk("err_idle", err, 0);
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_i_rdata", i_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    chk("rst_i_ready", i_ready, 0);
    chk("rst_d_ready", d_ready, 0);
    chk("rst_m_req", m_req, 0);
    chk("rst_m_we", m_we, 0);
    chk("rst_m_addr", m_addr, 0);
    chk("rst_m_wdata", m_wdata, 0);
    chk("rst_err", err, 0);
    chk("rst_stall", stall, 0);
    @(negedge clk);
    reset = 0;
    run_rand = 1;
    repeat (3000) @(posedge clk);
    run_rand = 0;
    for (int k = 0; k < 200 && (f_pend || d_pend || exp_q.size() != 0); k++)
      @(posedge clk);
    chk("drain", {30'd0, f_pend | d_pend, exp_q.size() != 0}, 0);
    hold_ack = 1;
    d_shot = 1;
    for (int k = 0; k < 20 && !m_req; k++) @(posedge clk);
    chk("shot_grant", m_req, 1);
    repeat (3) @(posedge clk);
    #2;
    reset = 1;
    #1;
    chk("mid_rst_m_req", m_req, 0);
    chk("mid_rst_m_addr", m_addr, 0);
    chk("mid_rst_d_ready", d_ready, 0);
    chk("mid_rst_d_rdata", d_rdata, 0);
    chk("mid_rst_i_rdata", i_rdata, 0);
    chk("mid_rst_err", err, 0);
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    reset = 0;
    hold_ack = 0;
    force_ack = 1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      chk("late_ack_d_ready", d_ready, 0);
      chk("late_ack_m_req", m_req, 0);
      chk("late_ack_err", err, 0);
    end
    force_ack = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
